unidade_controle: RTL and testbench
===================================

# unidade_controle

Control-unit FSM for the 16-bit multi-cycle processor. It loads an instruction word into an internal 9-bit IR. It then sequences the shared bus multiplexer (register-select one-hot, G and Din selects), the register/accumulator load enables and the ALU add/sub select over 1–3 execution steps. Done is asserted on the final step of each instruction.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Run  in  1  start request, sampled only in state T0
- Dado  in  16  instruction/immediate word; IR = Dado[15:7] = {III, XXX, YYY}
- GnZ  in  1  G register non-zero flag (used only by mvnz)
- controlReg  out  8  one-hot bus select R7..R0 (bit n = Rn drives bus)
- Gout  out  1  bus select G
- Din  out  1  bus select Dado
- Rin  out  8  one-hot register load enable R7..R0
- Ain  out  1  load A from bus
- Gin  out  1  load G from ALU
- AddSub  out  1  ALU op: 0 add, 1 subtract
- Done  out  1  last step of current instruction

## Operation
- States: T0 (fetch/idle), T1, T2, T3; state and IR are registered.
- All outputs are combinational decodes of {state, IR, GnZ}. There is no path from Run or Dado to any output.
- At most one of controlReg/Gout/Din is active in any cycle.
- T0: all outputs 0.
  - If Run=1: IR <= Dado[15:7], next state T1.
  - Otherwise stay in T0 and hold IR.
- Opcode 000, mv Rx,Ry:
  - T1: controlReg=onehot(YYY), Rin=onehot(XXX), Done=1, then T0.
- Opcode 001, mvi Rx,#D:
  - T1: Din=1, Rin=onehot(XXX), Done=1, then T0.
  - Dado must carry the immediate during T1.
- Opcode 010 (add) / 011 (sub):
  - T1: controlReg=onehot(XXX), Ain=1.
  - T2: controlReg=onehot(YYY), Gin=1, AddSub=III[0].
  - T3: Gout=1, Rin=onehot(XXX), Done=1, then T0.
- Opcode 100 (mvnz, when compiled in; see Configuration).
- Opcodes 101–111, and 100 when mvnz is compiled out: T1 asserts Done=1 only, with no bus drive and no loads, then T0.
- Run is ignored in T1–T3.
- Rx=Ry is legal. No special handling is required.

## Timing
- Reset (asynchronous): state=T0, IR=9'b0. All outputs go to 0 immediately and stay 0 while reset is high.
- Reset mid-instruction aborts the instruction; partial enables are not completed.
- Latency from the Run sample edge to Done:
  - mv/mvi/undefined/mvnz: 1 cycle (Done in T1).
  - add/sub: 3 cycles (Done in T3).
- Done is high for exactly one cycle per instruction. The cycle after Done is always T0.
- Back-to-back execution with Run held high:
  - The T0 following Done samples a new instruction.
  - Cost per instruction is (steps + 1) cycles.
- GnZ is sampled combinationally in T1 only.

## Configuration
- Macro UNIDADE_CONTROLE_MVNZ_EN.
- Defined: opcode 100 = mvnz Rx,Ry.
  - T1 with GnZ=1: controlReg=onehot(YYY), Rin=onehot(XXX), Done=1.
  - T1 with GnZ=0: Done=1 only.
- Undefined: opcode 100 is treated as undefined (Done only). GnZ remains a port and is ignored.

## Structure
- Shared package/include holds:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_MVNZ=3'b100
  - state encoding T0..T3 (2-bit)
  - IR field positions.
- One sub-module, decodificador_3x8: 3-bit to 8-bit one-hot with enable.
  - Instantiated twice: for XXX and for YYY.
  - Enable low gives 8'h00.

## Test plan
- mv R2,R5: Dado=16'h0A80, Run=1 for one cycle.
  - Next cycle: controlReg=8'h20, Rin=8'h04, Done=1.
  - Following cycle: all outputs 0.
- mvi R7: Dado=16'h3C00.
  - T1: Din=1, Rin=8'h80, Done=1, controlReg=8'h00.
- sub R1,R3: Dado=16'h6580.
  - T1: controlReg=8'h02, Ain=1.
  - T2: controlReg=8'h08, Gin=1, AddSub=1.
  - T3: Gout=1, Rin=8'h02, Done=1.
  - add (16'h4580) is the same with AddSub=0.
- Reset asserted asynchronously during T2 of an add:
  - All outputs 0 before the next edge; state T0.
  - After reset release, a new mv executes normally.
- mvnz R0,R1: Dado=16'h8080.
  - Macro defined, GnZ=0: Done only.
  - Macro defined, GnZ=1: controlReg=8'h02, Rin=8'h01, Done=1.
  - Macro undefined: Done only for both GnZ values.
- Run held high with mv then add:
  - Done pulses at cycles 1 and 5 after the first sample.
  - One T0 cycle with all outputs 0 between the two instructions.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the multi-cycle processor control unit:
// opcodes, step-state encoding and instruction-register field layout.
package unidade_controle_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    // IR occupies the top nine bits of the instruction word
    localparam int IR_MSB = 15;
    localparam int IR_LSB = 7;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] iii;
        logic [2:0] xxx;
        logic [2:0] yyy;
    } ir_t;

endpackage

// File: rtl/unidade_controle_decodificador_3x8.sv
// 3-to-8 one-hot decoder with enable; enable low gives all zeros.
// Purely combinational, no latency, no flow control.
module decodificador_3x8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        if (en) begin
            y = 8'h01 << w;
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// Control-unit FSM: fetches IR from Dado in T0, sequences bus/load/ALU controls over T1..T3.
// Latency: Done one cycle after Run sample (three for add/sub); outputs decode {state, IR, GnZ}.
// No backpressure: Run is honoured only in T0. Optional mvnz via UNIDADE_CONTROLE_MVNZ_EN.
module unidade_controle
    import unidade_controle_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        Run,
    input  logic [15:0] Dado,
    input  logic        GnZ,
    output logic [7:0]  controlReg,
    output logic        Gout,
    output logic        Din,
    output logic [7:0]  Rin,
    output logic        Ain,
    output logic        Gin,
    output logic        AddSub,
    output logic        Done
);

    state_t     state;
    ir_t        ir;
    logic [7:0] x_onehot;
    logic [7:0] y_onehot;
    logic       unused_bits;

`ifdef UNIDADE_CONTROLE_MVNZ_EN
    assign unused_bits = ^Dado[IR_LSB-1:0];
`else
    assign unused_bits = ^{Dado[IR_LSB-1:0], GnZ};
`endif

    decodificador_3x8 u_dec_x (
        .w  (ir.xxx),
        .en (1'b1),
        .y  (x_onehot)
    );

    decodificador_3x8 u_dec_y (
        .w  (ir.yyy),
        .en (1'b1),
        .y  (y_onehot)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= T0;
            ir    <= '0;
        end else begin
            case (state)
                T0: begin
                    if (Run) begin
                        ir    <= ir_t'(Dado[IR_MSB:IR_LSB]);
                        state <= T1;
                    end
                end
                T1: begin
                    if (ir.iii == OP_ADD || ir.iii == OP_SUB) begin
                        state <= T2;
                    end else begin
                        state <= T0;
                    end
                end
                T2:      state <= T3;
                default: state <= T0;
            endcase
        end
    end

    // Reset forces state to T0, so every output clears without waiting for an edge
    always_comb begin
        controlReg = 8'h00;
        Gout       = 1'b0;
        Din        = 1'b0;
        Rin        = 8'h00;
        Ain        = 1'b0;
        Gin        = 1'b0;
        AddSub     = 1'b0;
        Done       = 1'b0;
        case (state)
            T1: begin
                case (ir.iii)
                    OP_MV: begin
                        controlReg = y_onehot;
                        Rin        = x_onehot;
                        Done       = 1'b1;
                    end
                    OP_MVI: begin
                        Din  = 1'b1;
                        Rin  = x_onehot;
                        Done = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        controlReg = x_onehot;
                        Ain        = 1'b1;
                    end
`ifdef UNIDADE_CONTROLE_MVNZ_EN
                    OP_MVNZ: begin
                        if (GnZ) begin
                            controlReg = y_onehot;
                            Rin        = x_onehot;
                        end
                        Done = 1'b1;
                    end
`endif
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                controlReg = y_onehot;
                Gin        = 1'b1;
                AddSub     = ir.iii[0];
            end
            T3: begin
                Gout = 1'b1;
                Rin  = x_onehot;
                Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed testbench for unidade_controle: each task drives one scenario and checks outputs inline.
module tb_unidade_controle;

    logic        clock;
    logic        reset;
    logic        Run;
    logic [15:0] Dado;
    logic        GnZ;
    logic [7:0]  controlReg;
    logic        Gout;
    logic        Din;
    logic [7:0]  Rin;
    logic        Ain;
    logic        Gin;
    logic        AddSub;
    logic        Done;

    int tests = 0;
    int fails = 0;
    logic [21:0] exp_v;

    unidade_controle dut (
        .clock      (clock),
        .reset      (reset),
        .Run        (Run),
        .Dado       (Dado),
        .GnZ        (GnZ),
        .controlReg (controlReg),
        .Gout       (Gout),
        .Din        (Din),
        .Rin        (Rin),
        .Ain        (Ain),
        .Gin        (Gin),
        .AddSub     (AddSub),
        .Done       (Done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [21:0] outs();
        return {controlReg, Gout, Din, Rin, Ain, Gin, AddSub, Done};
    endfunction

    function automatic logic [21:0] pk(input logic [7:0] cr, input logic g, input logic d,
                                       input logic [7:0] r, input logic a, input logic gi,
                                       input logic as, input logic dn);
        return {cr, g, d, r, a, gi, as, dn};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one instruction: Run high for a single sampling edge, leaves bench in T1
    task automatic issue(input logic [15:0] word);
        Dado = word;
        Run  = 1'b1;
        step();
        Run  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Run   = 1'b1;
        Dado  = 16'h0A80;
        GnZ   = 1'b1;
        #3;
        exp_v = '0;
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL reset_async got %h exp %h", outs(), exp_v);
        end
        step();
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL reset_held got %h exp %h", outs(), exp_v);
        end
        Run   = 1'b0;
        reset = 1'b0;
        step();
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL idle_after_reset got %h exp %h", outs(), exp_v);
        end
    endtask

    task automatic test_mv();
        issue(16'h0A80);
        exp_v = pk(8'h20, 0, 0, 8'h04, 0, 0, 0, 1);
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL mv_t1 got %h exp %h", outs(), exp_v);
        end
        step();
        exp_v = '0;
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL mv_back_t0 got %h exp %h", outs(), exp_v);
        end
    endtask

    task automatic test_mvi();
        issue(16'h3C00);
        exp_v = pk(8'h00, 0, 1, 8'h80, 0, 0, 0, 1);
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL mvi_t1 got %h exp %h", outs(), exp_v);
        end
        step();
    endtask

    task automatic test_addsub(input logic [15:0] word, input logic as);
        issue(word);
        exp_v = pk(8'h02, 0, 0, 8'h00, 1, 0, 0, 0);
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL addsub_t1 op=%h got %h exp %h", word, outs(), exp_v);
        end
        step();
        exp_v = pk(8'h08, 0, 0, 8'h00, 0, 1, as, 0);
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL addsub_t2 op=%h got %h exp %h", word, outs(), exp_v);
        end
        step();
        exp_v = pk(8'h00, 1, 0, 8'h02, 0, 0, 0, 1);
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL addsub_t3 op=%h got %h exp %h", word, outs(), exp_v);
        end
        step();
        exp_v = '0;
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL addsub_after got %h exp %h", outs(), exp_v);
        end
    endtask

    task automatic test_undefined();
        issue(16'hA000);
        exp_v = pk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL undef_t1 got %h exp %h", outs(), exp_v);
        end
        step();
    endtask

    task automatic test_reset_mid();
        issue(16'h4580);
        step();
        exp_v = pk(8'h08, 0, 0, 8'h00, 0, 1, 0, 0);
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL rstmid_t2 got %h exp %h", outs(), exp_v);
        end
        #2;
        reset = 1'b1;
        #1;
        exp_v = '0;
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL rstmid_async got %h exp %h", outs(), exp_v);
        end
        step();
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL rstmid_held got %h exp %h", outs(), exp_v);
        end
        #2;
        reset = 1'b0;
        step();
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL rstmid_no_resume got %h exp %h", outs(), exp_v);
        end
        issue(16'h0A80);
        exp_v = pk(8'h20, 0, 0, 8'h04, 0, 0, 0, 1);
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL rstmid_mv got %h exp %h", outs(), exp_v);
        end
        step();
    endtask

    task automatic test_mvnz(input logic gnz);
        GnZ = gnz;
        issue(16'h8080);
`ifdef UNIDADE_CONTROLE_MVNZ_EN
        if (gnz) exp_v = pk(8'h02, 0, 0, 8'h01, 0, 0, 0, 1);
        else     exp_v = pk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
`else
        exp_v = pk(8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
`endif
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL mvnz_gnz%0d got %h exp %h", gnz, outs(), exp_v);
        end
        step();
        exp_v = '0;
        tests++;
        if (outs() !== exp_v) begin
            fails++;
            $display("FAIL mvnz_after got %h exp %h", outs(), exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] seen [1:6];
        logic [21:0] want [1:6];
        want[1] = pk(8'h20, 0, 0, 8'h04, 0, 0, 0, 1);
        want[2] = '0;
        want[3] = pk(8'h02, 0, 0, 8'h00, 1, 0, 0, 0);
        want[4] = pk(8'h08, 0, 0, 8'h00, 0, 1, 0, 0);
        want[5] = pk(8'h00, 1, 0, 8'h02, 0, 0, 0, 1);
        want[6] = '0;
        Dado = 16'h0A80;
        Run  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            // Changing Dado mid-instruction must not disturb the mv in flight
            Dado = 16'h4580;
            if (c == 5) Run = 1'b0;
            seen[c] = outs();
        end
        for (int c = 1; c <= 6; c++) begin
            tests++;
            if (seen[c] !== want[c]) begin
                fails++;
                $display("FAIL b2b_cycle%0d got %h exp %h", c, seen[c], want[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mv();
        test_mvi();
        test_addsub(16'h6580, 1'b1);
        test_addsub(16'h4580, 1'b0);
        test_undefined();
        test_reset_mid();
        test_mvnz(1'b0);
        test_mvnz(1'b1);
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
